// File: rtl/mem_access_unit.sv
// Load/store initiator for the 64-bit word-addressed data RAM (RMW for sub-word stores).
// Optional MEM_MISALIGN_TRAP_EN: reject misaligned accesses instead of aligning them down.
module mem_access_unit #(
   parameter int WORD_ADDR_WIDTH = 10
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       REQ_VALID,
   output logic                       REQ_READY,
   input  logic                       REQ_WRITE,
   input  logic [2:0]                 REQ_FUNCT3,
   input  logic [WORD_ADDR_WIDTH+2:0] REQ_ADDRESS,
   input  logic [63:0]                REQ_WDATA,
   output logic                       RESP_VALID,
   input  logic                       RESP_READY,
   output logic [63:0]                RESP_RDATA,
   output logic                       RESP_ERR,
   output logic [WORD_ADDR_WIDTH-1:0] MEM_ADDRESS,
   output logic [63:0]                MEM_DATA_OUT,
   output logic                       MEM_WRITE_ENABLE,
   input  logic [63:0]                MEM_DATA_IN
);

   localparam int AW = WORD_ADDR_WIDTH + 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_t;

   state_t                     state_q, state_d;
   logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]                 off_q, off_d;
   logic [2:0]                 f3_q, f3_d;
   logic                       wr_q, wr_d;
   logic [63:0]                wdata_q, wdata_d;
   logic [63:0]                rbuf_q, rbuf_d;
   logic [63:0]                rdata_q, rdata_d;
   logic                       err_q, err_d;

   logic [2:0] req_lo_mask;
   logic [2:0] req_off;
   logic [2:0] req_off_al;
   logic       req_illegal;
   logic       req_reject;

   always_comb begin
      req_lo_mask = 3'b000;
      unique case (REQ_FUNCT3[1:0])
         2'd0: req_lo_mask = 3'b000;
         2'd1: req_lo_mask = 3'b001;
         2'd2: req_lo_mask = 3'b011;
         2'd3: req_lo_mask = 3'b111;
      endcase
   end

   assign req_off     = REQ_ADDRESS[2:0];
   assign req_off_al  = req_off & ~req_lo_mask;
   assign req_illegal = REQ_WRITE ? REQ_FUNCT3[2]
                                  : (REQ_FUNCT3 == 3'b111);

`ifdef MEM_MISALIGN_TRAP_EN
   logic req_misal;
   assign req_misal  = |(req_off & req_lo_mask);
   assign req_reject = req_illegal | req_misal;
`else
   assign req_reject = req_illegal;
`endif

   // Load path: shift the addressed bytes down, then extend by size.
   logic [63:0] rd_shift;
   logic [63:0] load_ext;

   assign rd_shift = MEM_DATA_IN >> {off_q, 3'b000};

   always_comb begin
      load_ext = '0;
      unique case (f3_q[1:0])
         2'd0: load_ext = f3_q[2] ? {56'b0, rd_shift[7:0]}
                                  : {{56{rd_shift[7]}}, rd_shift[7:0]};
         2'd1: load_ext = f3_q[2] ? {48'b0, rd_shift[15:0]}
                                  : {{48{rd_shift[15]}}, rd_shift[15:0]};
         2'd2: load_ext = f3_q[2] ? {32'b0, rd_shift[31:0]}
                                  : {{32{rd_shift[31]}}, rd_shift[31:0]};
         2'd3: load_ext = rd_shift;
      endcase
   end

   // Store path: splice the right-aligned store data into the read buffer.
   logic [7:0]  byte_mask;
   logic [63:0] wd_shift;
   logic [63:0] merged;

   always_comb begin
      byte_mask = 8'h00;
      unique case (f3_q[1:0])
         2'd0: byte_mask = 8'h01;
         2'd1: byte_mask = 8'h03;
         2'd2: byte_mask = 8'h0F;
         2'd3: byte_mask = 8'hFF;
      endcase
      byte_mask = byte_mask << off_q;
      wd_shift  = wdata_q << {off_q, 3'b000};
      merged    = '0;
      for (int i = 0; i < 8; i++) begin
         merged[i*8 +: 8] = byte_mask[i] ? wd_shift[i*8 +: 8]
                                         : rbuf_q[i*8 +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      off_d   = off_q;
      f3_d    = f3_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               addr_d  = REQ_ADDRESS[AW-1:3];
               off_d   = req_off_al;
               f3_d    = REQ_FUNCT3;
               wr_d    = REQ_WRITE;
               wdata_d = REQ_WDATA;
               rdata_d = '0;
               err_d   = 1'b0;
               if (req_reject) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (REQ_WRITE && REQ_FUNCT3[1:0] == 2'd3) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            rbuf_d = MEM_DATA_IN;
            if (wr_q) begin
               state_d = S_WRITE;
            end else begin
               rdata_d = load_ext;
               state_d = S_RESP;
            end
         end
         S_WRITE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (RESP_READY) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Strobe is decoded from the state flop so reset drops it at once.
   assign REQ_READY        = (state_q == S_IDLE);
   assign RESP_VALID       = (state_q == S_RESP);
   assign MEM_WRITE_ENABLE = (state_q == S_WRITE);
   assign MEM_ADDRESS      = addr_q;
   assign MEM_DATA_OUT     = MEM_WRITE_ENABLE ? merged : '0;
   assign RESP_RDATA       = rdata_q;
   assign RESP_ERR         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural RAM and byte-level model.
// Honours MEM_MISALIGN_TRAP_EN when expecting misaligned results.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b1;
   logic        REQ_VALID = 1'b0;
   logic        REQ_READY;
   logic        REQ_WRITE = 1'b0;
   logic [2:0]  REQ_FUNCT3 = '0;
   logic [12:0] REQ_ADDRESS = '0;
   logic [63:0] REQ_WDATA = '0;
   logic        RESP_VALID;
   logic        RESP_READY = 1'b1;
   logic [63:0] RESP_RDATA;
   logic        RESP_ERR;
   logic [9:0]  MEM_ADDRESS;
   logic [63:0] MEM_DATA_OUT;
   logic        MEM_WRITE_ENABLE;
   logic [63:0] MEM_DATA_IN;

   mem_access_unit #(.WORD_ADDR_WIDTH(10)) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID),
      .REQ_READY(REQ_READY),
      .REQ_WRITE(REQ_WRITE),
      .REQ_FUNCT3(REQ_FUNCT3),
      .REQ_ADDRESS(REQ_ADDRESS),
      .REQ_WDATA(REQ_WDATA),
      .RESP_VALID(RESP_VALID),
      .RESP_READY(RESP_READY),
      .RESP_RDATA(RESP_RDATA),
      .RESP_ERR(RESP_ERR),
      .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_DATA_OUT(MEM_DATA_OUT),
      .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE),
      .MEM_DATA_IN(MEM_DATA_IN)
   );

   always #5 CLK = ~CLK;

   logic [63:0] ram [1024];
   logic [63:0] shadow [1024];

   assign MEM_DATA_IN = ram[MEM_ADDRESS];

   always @(posedge CLK) begin
      if (MEM_WRITE_ENABLE) ram[MEM_ADDRESS] <= MEM_DATA_OUT;
   end

   int          cyc = 0;
   int          we_cnt = 0;
   int          we_cyc = 0;
   logic [9:0]  we_addr = '0;
   logic [63:0] we_data = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (MEM_WRITE_ENABLE) begin
         we_cnt  = we_cnt + 1;
         we_cyc  = cyc;
         we_addr = MEM_ADDRESS;
         we_data = MEM_DATA_OUT;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          nwr;
      logic [9:0]  waddr;
      logic [63:0] wdata;
   } exp_t;

   exp_t sb [$];

   function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                  input logic [12:0] addr,
                                  input logic [63:0] wd);
      exp_t        e;
      int          sz;
      int          w;
      int          off;
      logic        ill;
      logic        mis;
      logic [63:0] v;
      sz  = 1 << f3[1:0];
      w   = int'(addr[12:3]);
      off = int'(addr[2:0]);
      ill = wr ? f3[2] : (f3 == 3'b111);
      mis = (off % sz) != 0;
      e.rdata = '0;
      e.err   = 1'b0;
      e.lat   = 1;
      e.nwr   = 0;
      e.waddr = addr[12:3];
      e.wdata = '0;
      if (ill) begin
         e.err = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
      end else if (mis) begin
         e.err = 1'b1;
`endif
      end else begin
         off = off - (off % sz);
         if (!wr) begin
            v = '0;
            for (int b = 0; b < sz; b++)
               v[8*b +: 8] = shadow[w][8*(off+b) +: 8];
            if (!f3[2] && v[8*sz-1])
               for (int b = sz; b < 8; b++) v[8*b +: 8] = 8'hFF;
            e.rdata = v;
            e.lat   = 2;
         end else begin
            for (int b = 0; b < sz; b++)
               shadow[w][8*(off+b) +: 8] = wd[8*b +: 8];
            e.nwr   = 1;
            e.wdata = shadow[w];
            e.lat   = (sz == 8) ? 2 : 3;
         end
      end
      return e;
   endfunction

   task automatic do_req(input logic wr, input logic [2:0] f3,
                         input logic [12:0] addr, input logic [63:0] wd,
                         input int hold);
      exp_t        e;
      int          lat;
      int          we0;
      int          acc;
      logic [63:0] rd0;
      logic        er0;
      sb.push_back(model(wr, f3, addr, wd));
      chk("req_ready_idle", 64'(REQ_READY), 64'd1);
      REQ_VALID   = 1'b1;
      REQ_WRITE   = wr;
      REQ_FUNCT3  = f3;
      REQ_ADDRESS = addr;
      REQ_WDATA   = wd;
      RESP_READY  = (hold == 0);
      we0 = we_cnt;
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      acc = cyc;
      lat = 1;
      while (!RESP_VALID && lat < 20) begin
         chk("req_ready_busy", 64'(REQ_READY), 64'd0);
         @(posedge CLK);
         #1;
         lat++;
      end
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("rdata", RESP_RDATA, e.rdata);
      chk("err", 64'(RESP_ERR), 64'(e.err));
      chk("we_pulses", 64'(we_cnt - we0), 64'(e.nwr));
      if (e.nwr == 1) begin
         chk("we_cycle", 64'(we_cyc - acc + 1), 64'(e.lat - 1));
         chk("we_addr", 64'(we_addr), 64'(e.waddr));
         chk("we_data", we_data, e.wdata);
      end
      rd0 = RESP_RDATA;
      er0 = RESP_ERR;
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 64'(RESP_VALID), 64'd1);
         chk("hold_rdata", RESP_RDATA, rd0);
         chk("hold_err", 64'(RESP_ERR), 64'(er0));
         chk("hold_req_ready", 64'(REQ_READY), 64'd0);
         @(posedge CLK);
         #1;
      end
      RESP_READY = 1'b1;
      @(posedge CLK);
      #1;
      chk("resp_cleared", 64'(RESP_VALID), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]    <= '0;
         shadow[i]  = '0;
      end
      ram[0]    <= 64'h1122334455667788;
      ram[4]    <= 64'hF0E0D0C0B0A09080;
      ram[5]    <= 64'h8877665544332211;
      ram[6]    <= 64'h1111111111111111;
      ram[1023] <= 64'hDEADBEEFCAFEF00D;
      shadow[0]    = 64'h1122334455667788;
      shadow[4]    = 64'hF0E0D0C0B0A09080;
      shadow[5]    = 64'h8877665544332211;
      shadow[6]    = 64'h1111111111111111;
      shadow[1023] = 64'hDEADBEEFCAFEF00D;

      #2 RESET_N = 1'b0;
      #1;
      chk("rst_req_ready", 64'(REQ_READY), 64'd1);
      chk("rst_resp_valid", 64'(RESP_VALID), 64'd0);
      chk("rst_resp_err", 64'(RESP_ERR), 64'd0);
      chk("rst_resp_rdata", RESP_RDATA, 64'd0);
      chk("rst_we", 64'(MEM_WRITE_ENABLE), 64'd0);
      chk("rst_mem_addr", 64'(MEM_ADDRESS), 64'd0);
      chk("rst_mem_dout", MEM_DATA_OUT, 64'd0);
      repeat (2) @(posedge CLK);
      #1 RESET_N = 1'b1;
      @(posedge CLK);
      #1;

      do_req(1'b0, 3'b000, 13'h02F, 64'd0, 0);
      do_req(1'b0, 3'b100, 13'h02F, 64'd0, 0);
      do_req(1'b1, 3'b001, 13'h012, 64'hABCD, 0);
      chk("ram_word2", ram[2], 64'h00000000ABCD0000);
      do_req(1'b1, 3'b011, 13'h018, 64'h0123456789ABCDEF, 0);
      chk("ram_word3", ram[3], 64'h0123456789ABCDEF);
      do_req(1'b0, 3'b010, 13'h021, 64'd0, 5);
      do_req(1'b0, 3'b011, 13'h028, 64'd0, 0);
      do_req(1'b0, 3'b111, 13'h040, 64'd0, 0);
      do_req(1'b1, 3'b100, 13'h040, 64'h55, 0);
      chk("ram_word8", ram[8], 64'd0);
      do_req(1'b0, 3'b001, 13'h003, 64'd0, 0);
      do_req(1'b0, 3'b101, 13'h006, 64'd0, 0);
      do_req(1'b0, 3'b110, 13'h004, 64'd0, 0);
      do_req(1'b0, 3'b011, 13'h1FF8, 64'd0, 0);
      do_req(1'b1, 3'b010, 13'h1FFC, 64'hCAFEBABE12345678, 0);
      do_req(1'b0, 3'b011, 13'h1FF8, 64'd0, 0);
      chk("ram_top", ram[1023], shadow[1023]);

      for (int n = 0; n < 40; n++) begin
         logic        wr;
         logic [2:0]  f3;
         logic [12:0] a;
         wr = 1'($urandom % 2);
         f3 = wr ? 3'($urandom % 4) : 3'($urandom % 7);
         a  = 13'(((8 + $urandom % 8) << 3) | ($urandom % 8));
         do_req(wr, f3, a, {$urandom, $urandom}, int'($urandom % 3));
      end
      for (int i = 8; i < 16; i++) chk("ram_rand", ram[i], shadow[i]);

      // Abort an SB while its write strobe is up.
      REQ_VALID   = 1'b1;
      REQ_WRITE   = 1'b1;
      REQ_FUNCT3  = 3'b000;
      REQ_ADDRESS = 13'h030;
      REQ_WDATA   = 64'h5A;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      @(posedge CLK);
      #1;
      chk("abort_we_before", 64'(MEM_WRITE_ENABLE), 64'd1);
      RESET_N = 1'b0;
      #1;
      chk("abort_we_after", 64'(MEM_WRITE_ENABLE), 64'd0);
      chk("abort_resp_valid", 64'(RESP_VALID), 64'd0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;
      @(posedge CLK);
      #1;
      chk("abort_req_ready", 64'(REQ_READY), 64'd1);
      chk("abort_word6", ram[6], shadow[6]);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
